conbus_initiator: RTL and testbench
===================================

// Module: conbus_initiator
// PURPOSE
//  Wishbone (classic, single-transfer) bus master for the conbus test path.
//  Takes one command at a time over a valid/ready port, runs one WB read or
//  write cycle, and returns the read data or a timeout flag on a valid/ready
//  response port. Pairs with WB slaves such as the debug-LED peripheral.
//  Used by bring-up logic to exercise slaves without the CPU.
// PARAMETERS
//  TIMEOUT_W  10    width of the ack-wait counter
//  TIMEOUT    1000  max cycles with cyc/stb high and no ack before abort (1..2^TIMEOUT_W-1)
// PORTS
//  sys_clk      in   1   system clock, all logic on rising edge
//  sys_rst      in   1   asynchronous, active-high reset
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   block can accept a command (high only in IDLE)
//  cmd_we       in   1   1 = write, 0 = read
//  cmd_adr      in   32  byte address
//  cmd_dat      in   32  write data (ignored on reads)
//  cmd_sel      in   4   byte selects
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   consumer takes response
//  rsp_dat      out  32  read data; 0 for writes; 32'hFFFFFFFF on timeout
//  rsp_timeout  out  1   1 = cycle aborted without ack
//  wb_adr_o     out  32  WB address
//  wb_dat_o     out  32  WB write data
//  wb_dat_i     in   32  WB read data
//  wb_sel_o     out  4   WB byte selects
//  wb_cyc_o     out  1   WB cycle
//  wb_stb_o     out  1   WB strobe
//  wb_we_o      out  1   WB write enable
//  wb_ack_i     in   1   WB acknowledge
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs 0 (cmd_ready rises once
//   in IDLE, i.e. 1 while sys_rst low and state IDLE); counter=0. Reset during
//   an active bus cycle drops cyc/stb immediately; the command is lost.
//  All wb_* outputs registered; adr/dat/sel/we stable for the whole cycle.
//  FSM states IDLE, BUS, RESP (encodings in package):
//   IDLE: cmd_ready=1. On cmd_valid&cmd_ready at edge N: latch cmd into
//    wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o, set cyc=stb=1, counter=0, -> BUS.
//    cyc/stb therefore first high in cycle N+1.
//   BUS: cmd_ready=0. wb_ack_i sampled each edge.
//    ack=1: cyc=stb=0 next cycle; rsp_dat = we ? 0 : wb_dat_i;
//     rsp_timeout=0; rsp_valid=1; -> RESP.
//    ack=0 and counter==TIMEOUT-1: cyc=stb=0; rsp_dat=32'hFFFFFFFF;
//     rsp_timeout=1; rsp_valid=1; -> RESP.
//    else counter+1 (never wraps; bounded by TIMEOUT).
//    ack and timeout on the same edge: ack wins (normal completion).
//   RESP: rsp_valid=1, rsp_dat/rsp_timeout held. On rsp_ready: rsp_valid=0
//    next cycle, -> IDLE. No new command accepted in the same cycle.
//  Latency: slave acking in its first strobed cycle gives rsp_valid high 2
//   cycles after command acceptance; each slave wait state adds 1.
//  Throughput: one transfer at a time; min 3 cycles per command.
//  wb_ack_i outside BUS (stray ack) ignored; no state or output change.
//  wb_dat_o/wb_adr_o keep last values after the cycle (don't-care to slaves).
// STRUCTURE
//  Package conbus_pkg: FSM state localparams (IDLE=2'd0, BUS=2'd1,
//   RESP=2'd2), TIMEOUT_DATA=32'hFFFFFFFF, WB width constants (32/4).
//  No sub-module required; the ack-wait counter is inline. Single always
//   block for sequential state/outputs, one combinational next-state block.
// TESTING
//  1 Write adr=0x0000_0010 dat=0x0000_0001 sel=0xF, slave acks 1st strobed
//    cycle -> one cyc/stb pulse of 1 cycle, we=1, rsp_valid 2 cycles after
//    accept, rsp_dat=0, rsp_timeout=0.
//  2 Read adr=0x0000_0020, slave with 2 wait states returns 0xDEADBEEF ->
//    cyc/stb high exactly 3 cycles, rsp_dat=0xDEADBEEF, rsp_timeout=0.
//  3 Read to silent slave, TIMEOUT=8 -> cyc/stb high exactly 8 cycles then
//    low, rsp_timeout=1, rsp_dat=0xFFFFFFFF.
//  4 rsp_ready held low 5 cycles after completion -> rsp_valid/rsp_dat
//    stable, cmd_ready=0 and cmd_valid ignored until handshake, then IDLE.
//  5 Ack arrives on the cycle counter==TIMEOUT-1 -> rsp_timeout=0, read data
//    returned; stray ack pulse in IDLE -> no response, no bus activity.
//  6 sys_rst asserted mid BUS -> cyc/stb/rsp_valid low without waiting for
//    clock; after release cmd_ready=1 and next command runs normally.

Source files
------------

// File: rtl/conbus_pkg.sv
// Shared constants for the conbus Wishbone initiator: FSM encodings,
// timeout response data and Wishbone bus widths.
package conbus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam logic [WB_DAT_W-1:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/conbus_initiator.sv
// Single-transfer Wishbone classic master: one command in, one bus cycle,
// one response (read data or timeout) out.
module conbus_initiator
  import conbus_pkg::*;
#(
  parameter int TIMEOUT_W = 10,
  parameter int TIMEOUT   = 1000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_dat,
  input  logic [WB_SEL_W-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic                rsp_timeout,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  input  logic                wb_ack_i
);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 w_tmo;
  logic [WB_ADR_W-1:0]  r_adr;
  logic [WB_DAT_W-1:0]  r_dat;
  logic [WB_SEL_W-1:0]  r_sel;
  logic                 r_we;
  logic                 r_cyc;
  logic                 r_rsp_valid;
  logic [WB_DAT_W-1:0]  r_rsp_dat;
  logic                 r_rsp_timeout;

  // Last permitted wait cycle; an ack on this same edge still wins.
  assign w_tmo = (r_cnt == TIMEOUT_W'(TIMEOUT - 1));

  assign cmd_ready   = (r_state == ST_IDLE) && !sys_rst;
  assign wb_adr_o    = r_adr;
  assign wb_dat_o    = r_dat;
  assign wb_sel_o    = r_sel;
  assign wb_we_o     = r_we;
  assign wb_cyc_o    = r_cyc;
  assign wb_stb_o    = r_cyc;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_dat     = r_rsp_dat;
  assign rsp_timeout = r_rsp_timeout;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (cmd_valid)           w_state_nxt = ST_BUS;
      ST_BUS:  if (wb_ack_i || w_tmo)   w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready)           w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_adr         <= '0;
      r_dat         <= '0;
      r_sel         <= '0;
      r_we          <= 1'b0;
      r_cyc         <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_dat     <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_adr <= cmd_adr;
            r_dat <= cmd_dat;
            r_sel <= cmd_sel;
            r_we  <= cmd_we;
            r_cyc <= 1'b1;
            r_cnt <= '0;
          end
        end
        ST_BUS: begin
          if (wb_ack_i) begin
            r_cyc         <= 1'b0;
            r_rsp_dat     <= r_we ? '0 : wb_dat_i;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
          end else if (w_tmo) begin
            r_cyc         <= 1'b0;
            r_rsp_dat     <= TIMEOUT_DATA;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: r_cyc <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_conbus_initiator.sv
// Directed bench for conbus_initiator with a small wait-state Wishbone slave.
module tb_conbus_initiator;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_dat;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;

  logic        slv_en;
  int          slv_waits;
  logic [31:0] slv_data;
  int          slv_cnt;
  logic        stray_ack;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  conbus_initiator #(.TIMEOUT_W(10), .TIMEOUT(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_timeout(rsp_timeout),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i)
  );

  // Slave acks after slv_waits strobed cycles without ack.
  always_ff @(posedge sys_clk) begin
    if (!wb_cyc_o) slv_cnt <= 0;
    else if (wb_stb_o && !wb_ack_i) slv_cnt <= slv_cnt + 1;
  end
  assign wb_ack_i = stray_ack | (slv_en & wb_cyc_o & wb_stb_o & (slv_cnt == slv_waits));
  assign wb_dat_i = slv_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Issue one command and follow it until rsp_valid; rsp_ready is left low.
  task automatic run_cmd(input string tag, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         output int cyc_hi, output int lat, output int bad);
    logic done;
    chk({tag, "_rdy_pre"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    step();
    cmd_valid = 1'b0;
    lat = 1; cyc_hi = 0; bad = 0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (rsp_valid) begin
        done = 1'b1;
        if (wb_cyc_o || wb_stb_o) bad++;
      end else begin
        if (wb_cyc_o) begin
          cyc_hi++;
          if (wb_stb_o !== 1'b1 || wb_adr_o !== adr || wb_we_o !== we ||
              wb_sel_o !== sel || cmd_ready !== 1'b0) bad++;
          if (we && wb_dat_o !== dat) bad++;
        end
        step();
        lat++;
      end
    end
    chk({tag, "_rsp_seen"}, 32'(done), 32'd1);
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdy_post"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int cyc_hi, lat, bad;
    logic [31:0] held_dat;
    sys_rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b0; slv_en = 1'b1; slv_waits = 0;
    slv_data = '0; stray_ack = 1'b0;
    #1;
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    step(); step();
    sys_rst = 1'b0;
    #1;
    chk("rst_rel_ready", 32'(cmd_ready), 32'd1);
    step();

    // 1: write, zero wait states
    slv_waits = 0; slv_data = 32'hA5A5_A5A5;
    run_cmd("t1", 1'b1, 32'h0000_0010, 32'h0000_0001, 4'hF, cyc_hi, lat, bad);
    chk("t1_cyc_len", 32'(cyc_hi), 32'd1);
    chk("t1_latency", 32'(lat), 32'd2);
    chk("t1_bus_fields", 32'(bad), 32'd0);
    chk("t1_rsp_dat", rsp_dat, 32'd0);
    chk("t1_rsp_tmo", 32'(rsp_timeout), 32'd0);
    finish_rsp("t1");

    // 2: read, two wait states
    slv_waits = 2; slv_data = 32'hDEAD_BEEF;
    run_cmd("t2", 1'b0, 32'h0000_0020, 32'h1234_5678, 4'hF, cyc_hi, lat, bad);
    chk("t2_cyc_len", 32'(cyc_hi), 32'd3);
    chk("t2_latency", 32'(lat), 32'd4);
    chk("t2_bus_fields", 32'(bad), 32'd0);
    chk("t2_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
    chk("t2_rsp_tmo", 32'(rsp_timeout), 32'd0);
    finish_rsp("t2");

    // 3: silent slave times out after 8 strobed cycles
    slv_en = 1'b0;
    run_cmd("t3", 1'b0, 32'h0000_0030, 32'h0, 4'h3, cyc_hi, lat, bad);
    chk("t3_cyc_len", 32'(cyc_hi), 32'd8);
    chk("t3_bus_fields", 32'(bad), 32'd0);
    chk("t3_rsp_dat", rsp_dat, 32'hFFFF_FFFF);
    chk("t3_rsp_tmo", 32'(rsp_timeout), 32'd1);

    // 4: consumer stalls 5 cycles while a new command is offered
    held_dat = rsp_dat;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h0000_0040; cmd_sel = 4'h1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_dat !== held_dat || rsp_timeout !== 1'b1 ||
          cmd_ready !== 1'b0 || wb_cyc_o !== 1'b0) bad++;
    end
    chk("t4_stall_hold", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    chk("t4_rsp_drop", 32'(rsp_valid), 32'd0);
    chk("t4_no_accept", 32'(wb_cyc_o), 32'd0);
    chk("t4_idle_ready", 32'(cmd_ready), 32'd1);
    step();
    chk("t4_still_idle", 32'(wb_cyc_o), 32'd0);

    // 5: ack on the last permitted cycle wins over timeout
    slv_en = 1'b1; slv_waits = 7; slv_data = 32'h0BAD_F00D;
    run_cmd("t5", 1'b0, 32'h0000_0050, 32'h0, 4'hF, cyc_hi, lat, bad);
    chk("t5_cyc_len", 32'(cyc_hi), 32'd8);
    chk("t5_latency", 32'(lat), 32'd9);
    chk("t5_rsp_dat", rsp_dat, 32'h0BAD_F00D);
    chk("t5_rsp_tmo", 32'(rsp_timeout), 32'd0);
    finish_rsp("t5");
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    chk("t5_stray_rsp", 32'(rsp_valid), 32'd0);
    chk("t5_stray_cyc", 32'(wb_cyc_o), 32'd0);
    step();
    chk("t5_stray_rsp2", 32'(rsp_valid), 32'd0);
    chk("t5_stray_ready", 32'(cmd_ready), 32'd1);

    // 6: asynchronous reset in the middle of a bus cycle
    slv_en = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0000_0060; cmd_sel = 4'hF;
    step();
    cmd_valid = 1'b0;
    step();
    chk("t6_cyc_before", 32'(wb_cyc_o), 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    chk("t6_cyc_async", 32'(wb_cyc_o), 32'd0);
    chk("t6_stb_async", 32'(wb_stb_o), 32'd0);
    chk("t6_rsp_async", 32'(rsp_valid), 32'd0);
    step();
    sys_rst = 1'b0;
    #1;
    chk("t6_ready_after", 32'(cmd_ready), 32'd1);
    slv_en = 1'b1; slv_waits = 1; slv_data = 32'h5555_AAAA;
    run_cmd("t6b", 1'b0, 32'h0000_0070, 32'h0, 4'hC, cyc_hi, lat, bad);
    chk("t6b_cyc_len", 32'(cyc_hi), 32'd2);
    chk("t6b_latency", 32'(lat), 32'd3);
    chk("t6b_bus_fields", 32'(bad), 32'd0);
    chk("t6b_rsp_dat", rsp_dat, 32'h5555_AAAA);
    finish_rsp("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
